mem_controller: RTL
===================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 8, number of requesters (LSUs or fetchers); minimum 1.
REQ-004 SHALL have parameter NUM_CHANNELS, default 4, number of memory channels; minimum 1, at most NUM_CONSUMERS.
REQ-005 SHALL have parameter WRITE_ENABLE, default 1; when 0, all write ports are tied inactive and write requests are ignored.
REQ-006 SHALL have these ports, listed as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- consumer_read_valid, in, NUM_CONSUMERS, read request per consumer.
- consumer_read_address, in, NUM_CONSUMERS x ADDR_BITS.
- consumer_read_ready, out, NUM_CONSUMERS, read data valid.
- consumer_read_data, out, NUM_CONSUMERS x DATA_BITS.
- consumer_write_valid, in, NUM_CONSUMERS.
- consumer_write_address, in, NUM_CONSUMERS x ADDR_BITS.
- consumer_write_data, in, NUM_CONSUMERS x DATA_BITS.
- consumer_write_ready, out, NUM_CONSUMERS, write done.
- mem_read_valid, out, NUM_CHANNELS.
- mem_read_address, out, NUM_CHANNELS x ADDR_BITS.
- mem_read_ready, in, NUM_CHANNELS, read data present this cycle.
- mem_read_data, in, NUM_CHANNELS x DATA_BITS.
- mem_write_valid, out, NUM_CHANNELS.
- mem_write_address, out, NUM_CHANNELS x ADDR_BITS.
- mem_write_data, out, NUM_CHANNELS x DATA_BITS.
- mem_write_ready, in, NUM_CHANNELS, write accepted this cycle.

Function
REQ-007 SHALL run one registered FSM per channel with states IDLE, READ_WAIT, WRITE_WAIT, RELAY.
REQ-008 SHALL keep a claimed bit and an owner index per channel, so that a consumer is served by at most one channel at a time.
REQ-009 SHALL grant in IDLE: each channel, scanned from index 0 upward within one cycle, claims the first unclaimed consumer with a pending read or write, starting the search at the round-robin pointer rr_ptr and wrapping modulo NUM_CONSUMERS.
REQ-010 SHALL ensure that a consumer granted to a lower-index channel in a cycle is not granted to a higher-index channel in the same cycle.
REQ-011 SHALL set rr_ptr, after any grant cycle, to (highest-scan-position granted consumer + 1) mod NUM_CONSUMERS; if no grant occurs, rr_ptr holds.
REQ-012 SHALL give read priority when one consumer asserts both read and write valid; the write is served in a later grant.
REQ-013 SHALL, on a read grant in cycle N, drive mem_read_valid=1 and mem_read_address=owner address from cycle N+1, in state READ_WAIT.
REQ-014 SHALL, in READ_WAIT, on sampling mem_read_ready=1: register mem_read_data into consumer_read_data[owner], set consumer_read_ready[owner]=1, drop mem_read_valid, and move to RELAY.
REQ-015 SHALL handle writes the same way: mem_write_valid, address and data are driven from N+1 in WRITE_WAIT; on mem_write_ready=1, set consumer_write_ready[owner]=1 and move to RELAY.
REQ-016 SHALL, in RELAY, hold the consumer ready until the consumer's corresponding valid is sampled 0; then clear ready and the claim and return to IDLE on the next edge. Minimum turnaround: grant to IDLE is 4 cycles with a zero-wait memory.
REQ-017 SHALL hold consumer_read_data stable while consumer_read_ready=1.
REQ-018 SHALL keep waiting indefinitely in READ_WAIT and WRITE_WAIT with no timeout; addresses are held constant.
REQ-019 SHALL keep consumer request addresses and data stable while valid is high; the controller samples them at the grant edge only.
REQ-020 SHALL not combinationally pass any memory-side input to any consumer output.

Reset
REQ-021 SHALL, on reset=0 asynchronously: put all FSMs in IDLE, clear all claims, set rr_ptr=0, and drive all valid/ready outputs to 0 and all address and data outputs to 0.
REQ-022 SHALL, on reset assertion mid-transaction, abandon the transaction silently; after release, no stale ready is issued.
REQ-023 SHALL make no grant earlier than the first rising edge after reset deasserts.

Verification
REQ-024 Single read: consumer 2 reads addr 0x10, memory returns 0xAB with zero wait -> consumer_read_ready[2]=1 with data 0xAB 3 cycles after valid; returns to IDLE after valid drops.
REQ-025 Contention: all 8 consumers read at once with 4 channels -> consumers 0-3 are granted first, on channels 0-3 in order; 4-7 are granted after release; each consumer gets exactly one ready.
REQ-026 Fairness: consumers 0 and 5 request continuously with NUM_CHANNELS=1 -> grants alternate 0,5,0,5.
REQ-027 Write with 3-cycle mem_write_ready stall: addr 0x20, data 0x5A -> mem_write_* held stable for 3 cycles; then consumer_write_ready pulses until valid drops.
REQ-028 Reset mid-READ_WAIT -> all outputs 0 immediately; a repeated request after release completes normally.
REQ-029 Read and write valid together on consumer 1 -> read completes first; the write is granted after the read's RELAY exits.

Source files
------------

// File: rtl/mem_controller.sv
// mem_controller: arbitrates NUM_CONSUMERS read/write requesters onto
// NUM_CHANNELS memory channels. Each channel runs its own small FSM. Grants
// are round-robin, and every consumer-facing output comes from a register.
module mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  state_t                           state_r [NUM_CHANNELS];
  logic [CW-1:0]                    owner_r [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]          claimed_r;
  logic [NUM_CHANNELS-1:0]          is_write_r;
  logic [CW-1:0]                    rr_ptr_r;

  logic [NUM_CONSUMERS-1:0]           cons_read_ready_r;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] cons_read_data_r;
  logic [NUM_CONSUMERS-1:0]           cons_write_ready_r;
  logic [NUM_CHANNELS-1:0]            mem_read_valid_r;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address_r;
  logic [NUM_CHANNELS-1:0]            mem_write_valid_r;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address_r;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data_r;

  logic [NUM_CONSUMERS-1:0] wv_s;
  logic [NUM_CONSUMERS-1:0] busy_s;
  logic [NUM_CONSUMERS-1:0] taken_s;
  logic [NUM_CHANNELS-1:0]  grant_s;
  logic [NUM_CHANNELS-1:0]  grant_rd_s;
  logic [NUM_CHANNELS-1:0]  found_s;
  logic [NUM_CHANNELS-1:0]  release_s;
  logic [CW-1:0]            grant_idx_s [NUM_CHANNELS];
  logic [CW-1:0]            idx_s;
  logic [CW-1:0]            rr_next_s;
  logic                     any_grant_s;
  int                       max_pos_s;

  // With writes disabled, write requests never reach the arbiter.
  assign wv_s = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

  assign consumer_read_ready  = cons_read_ready_r;
  assign consumer_read_data   = cons_read_data_r;
  assign consumer_write_ready = (WRITE_ENABLE != 0) ? cons_write_ready_r : '0;
  assign mem_read_valid       = mem_read_valid_r;
  assign mem_read_address     = mem_read_address_r;
  assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_write_valid_r : '0;
  assign mem_write_address    = (WRITE_ENABLE != 0) ? mem_write_address_r : '0;
  assign mem_write_data       = (WRITE_ENABLE != 0) ? mem_write_data_r : '0;

  // Round-robin grant: idle channels, lowest index first, take the first free pending consumer from rr_ptr.
  always_comb begin
    busy_s      = '0;
    taken_s     = '0;
    grant_s     = '0;
    grant_rd_s  = '0;
    found_s     = '0;
    idx_s       = '0;
    any_grant_s = 1'b0;
    max_pos_s   = 0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_idx_s[ch] = '0;
      if (claimed_r[ch]) begin
        busy_s[owner_r[ch]] = 1'b1;
      end else begin
        busy_s = busy_s;
      end
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (state_r[ch] == IDLE) begin
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx_s = CW'((int'(rr_ptr_r) + k) % NUM_CONSUMERS);
          if (!found_s[ch] && !busy_s[idx_s] && !taken_s[idx_s] &&
              (consumer_read_valid[idx_s] || wv_s[idx_s])) begin
            found_s[ch]     = 1'b1;
            taken_s[idx_s]  = 1'b1;
            grant_s[ch]     = 1'b1;
            grant_idx_s[ch] = idx_s;
            // A read wins over a simultaneous write from the same consumer.
            grant_rd_s[ch]  = consumer_read_valid[idx_s];
            any_grant_s     = 1'b1;
            max_pos_s       = (k > max_pos_s) ? k : max_pos_s;
          end else begin
            found_s[ch] = found_s[ch];
          end
        end
      end else begin
        found_s[ch] = 1'b0;
      end
    end
    if (any_grant_s) begin
      rr_next_s = CW'((int'(rr_ptr_r) + max_pos_s + 1) % NUM_CONSUMERS);
    end else begin
      rr_next_s = rr_ptr_r;
    end
  end

  // A relay ends once the owner drops the valid matching the served request.
  always_comb begin
    release_s = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (is_write_r[ch]) begin
        release_s[ch] = !wv_s[owner_r[ch]];
      end else begin
        release_s[ch] = !consumer_read_valid[owner_r[ch]];
      end
    end
  end

  // Per-channel FSM plus all registered consumer- and memory-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r            <= '0;
      claimed_r           <= '0;
      is_write_r          <= '0;
      cons_read_ready_r   <= '0;
      cons_read_data_r    <= '0;
      cons_write_ready_r  <= '0;
      mem_read_valid_r    <= '0;
      mem_read_address_r  <= '0;
      mem_write_valid_r   <= '0;
      mem_write_address_r <= '0;
      mem_write_data_r    <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_r[ch] <= IDLE;
        owner_r[ch] <= '0;
      end
    end else begin
      rr_ptr_r <= rr_next_s;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (state_r[ch])
          IDLE: begin
            if (grant_s[ch]) begin
              claimed_r[ch]  <= 1'b1;
              owner_r[ch]    <= grant_idx_s[ch];
              is_write_r[ch] <= !grant_rd_s[ch];
              if (grant_rd_s[ch]) begin
                state_r[ch]          <= READ_WAIT;
                mem_read_valid_r[ch] <= 1'b1;
                mem_read_address_r[ch*ADDR_BITS +: ADDR_BITS] <=
                  consumer_read_address[grant_idx_s[ch]*ADDR_BITS +: ADDR_BITS];
              end else begin
                state_r[ch]           <= WRITE_WAIT;
                mem_write_valid_r[ch] <= 1'b1;
                mem_write_address_r[ch*ADDR_BITS +: ADDR_BITS] <=
                  consumer_write_address[grant_idx_s[ch]*ADDR_BITS +: ADDR_BITS];
                mem_write_data_r[ch*DATA_BITS +: DATA_BITS] <=
                  consumer_write_data[grant_idx_s[ch]*DATA_BITS +: DATA_BITS];
              end
            end
          end
          READ_WAIT: begin
            if (mem_read_ready[ch]) begin
              mem_read_valid_r[ch]               <= 1'b0;
              cons_read_ready_r[owner_r[ch]]     <= 1'b1;
              cons_read_data_r[owner_r[ch]*DATA_BITS +: DATA_BITS] <=
                mem_read_data[ch*DATA_BITS +: DATA_BITS];
              state_r[ch]                        <= RELAY;
            end
          end
          WRITE_WAIT: begin
            if (mem_write_ready[ch]) begin
              mem_write_valid_r[ch]           <= 1'b0;
              cons_write_ready_r[owner_r[ch]] <= 1'b1;
              state_r[ch]                     <= RELAY;
            end
          end
          RELAY: begin
            if (release_s[ch]) begin
              if (is_write_r[ch]) begin
                cons_write_ready_r[owner_r[ch]] <= 1'b0;
              end else begin
                cons_read_ready_r[owner_r[ch]] <= 1'b0;
              end
              claimed_r[ch] <= 1'b0;
              state_r[ch]   <= IDLE;
            end
          end
          default: begin
            claimed_r[ch] <= 1'b0;
            state_r[ch]   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
